llc_mem_beat_adapter: RTL and testbench
=======================================

# llc_mem_beat_adapter

Downstream stage of the LLC core's memory-request port. It takes whole-line memory requests (read or write-back), serializes them into word-wide beats on the narrow external memory bus, gathers read-data beats back into a full line, and returns that line on the LLC memory-response port. It owns its own valid/ready handshakes on both sides and holds at most one line transaction in flight.

## Interface
Parameters:
- WORD_BITS, 64, width of one bus data beat.
- WORDS_PER_LINE, 2, beats per cache line; power of two, ≥2.
- LINE_ADDR_BITS, 28, width of the line address on the LLC side.
- OFF_BITS, derived: $clog2(WORDS_PER_LINE*WORD_BITS/8), byte offset bits within a line.

Ports (LINE = WORDS_PER_LINE*WORD_BITS, BADDR = LINE_ADDR_BITS+OFF_BITS):
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_req_valid  in  1  LLC line request valid.
- mem_req_ready  out  1  adapter accepts request.
- mem_req_hwrite  in  1  1 = write-back, 0 = line fill.
- mem_req_addr  in  LINE_ADDR_BITS  line address.
- mem_req_line  in  LINE  write-back data, word 0 in bits [WORD_BITS-1:0].
- mem_rsp_valid  out  1  filled line available.
- mem_rsp_ready  in  1  LLC consumes line.
- mem_rsp_line  out  LINE  filled line.
- bus_req_valid  out  1  bus beat valid (read command or write beat).
- bus_req_ready  in  1  bus accepts beat.
- bus_req_write  out  1  beat is a write.
- bus_req_addr  out  BADDR  byte address of the beat's word.
- bus_req_wdata  out  WORD_BITS  write data.
- bus_req_last  out  1  last beat of the line (always 1 for read command).
- bus_rd_valid  in  1  read-data beat valid.
- bus_rd_ready  out  1  adapter accepts read-data beat.
- bus_rd_data  in  WORD_BITS  read-data word.
- bus_wack_valid  in  1  write acknowledge; used only with LLC_MEM_WACK_EN.

## Operation
- States: IDLE, RD_CMD, RD_DATA, RD_RSP, WR_BEAT, WR_ACK (WR_ACK only with LLC_MEM_WACK_EN).
- IDLE: mem_req_ready=1. On handshake latch hwrite, addr, line; clear beat counter (log2 WORDS_PER_LINE bits); go WR_BEAT if hwrite else RD_CMD.
- RD_CMD: bus_req_valid=1, write=0, addr={line_addr, OFF_BITS'0}, last=1, wdata=0. On bus_req_ready → RD_DATA.
- RD_DATA: bus_rd_ready=1. Each bus_rd_valid beat stored into word slot [cnt*WORD_BITS +: WORD_BITS], cnt++. Beat with cnt==WORDS_PER_LINE-1 → RD_RSP, cnt wraps to 0.
- RD_RSP: mem_rsp_valid=1, mem_rsp_line=assembled buffer (stable while valid). On mem_rsp_ready → IDLE.
- WR_BEAT: bus_req_valid=1, write=1, addr={line_addr, cnt, zero byte bits}, wdata=word cnt of latched line, last=(cnt==WORDS_PER_LINE-1). On accept cnt++; last beat accepted → IDLE (or WR_ACK with macro).
- Outputs outside their owning state are 0 (valid/ready) and hold last value (data/addr are don't-care but must not be X after reset).
- bus_rd_valid outside RD_DATA is ignored (bus_rd_ready=0, no buffer change).
- Write-backs produce no mem_rsp.

## Timing
- Reset: state=IDLE; mem_req_ready=1 once rst deasserts; mem_rsp_valid, bus_req_valid, bus_rd_ready, bus_req_write, bus_req_last=0; bus_req_addr, bus_req_wdata, mem_rsp_line, counter=0.
- Request accepted cycle T → first bus_req_valid in T+1 (registered state, no combinational req→bus path).
- Read, zero-wait bus: cmd accepted T+1, beats T+2..T+1+W, mem_rsp_valid at T+2+W, IDLE the cycle after rsp handshake; next request earliest the cycle after.
- Write, zero-wait: beats T+1..T+W, mem_req_ready again at T+W+1.
- Back-pressure: bus_req_* and mem_rsp_* hold stable while valid && !ready.
- Reset mid-transaction: immediate return to IDLE, partial line and counter discarded, no response emitted.

## Configuration
- LLC_MEM_WACK_EN defined: after last write beat enter WR_ACK; remain (mem_req_ready=0) until bus_wack_valid=1, then IDLE. Ack arriving in any other state is ignored.
- Undefined: no WR_ACK state; bus_wack_valid unused; write completes on last-beat acceptance.

## Test plan
- Read, addr=0x0000123, W=2, bus zero-wait, data 0xAAAA…, 0x5555… → cmd addr 0x1230 (OFF_BITS=4), last=1; mem_rsp_line={0x5555…,0xAAAA…} at T+4.
- Write addr=0x0000040, line={0x22,0x11} → beats addr 0x400 wdata 0x11 last=0, addr 0x408 wdata 0x22 last=1; no mem_rsp.
- Random bus_req_ready/bus_rd_valid/mem_rsp_ready stalls (50%) over 1000 mixed requests → outputs stable under stall, read data matches reference memory.
- rst asserted after first read beat → all valids 0, next read returns only the new line's data.
- With LLC_MEM_WACK_EN, ack delayed 5 cycles → mem_req_ready stays 0 for 5 cycles after last beat, 1 the cycle after ack.
- Stray bus_rd_valid in IDLE → bus_rd_ready=0, subsequent read line unaffected.

Source files
------------

// File: rtl/llc_mem_beat_adapter.sv
// llc_mem_beat_adapter
//
// Bridges the LLC's whole-line memory port to a word-wide external memory bus.
// A line fill becomes one read command followed by WORDS_PER_LINE read-data beats.
// The beats are gathered into a line buffer and returned on mem_rsp_*.
// A write-back becomes WORDS_PER_LINE write beats and produces no response.
// At most one line transaction is in flight.
//
// Optional feature: define LLC_MEM_WACK_EN to hold each write-back until
// bus_wack_valid is seen after the last beat. Without it, bus_wack_valid is unused.
//
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-low reset
//   mem_req_*_i/_o         LLC line request (valid/ready, hwrite, line address, line data)
//   mem_rsp_*_i/_o         LLC line response (valid/ready, filled line)
//   bus_req_*_i/_o         bus beat request (valid/ready, write, byte address, wdata, last)
//   bus_rd_*_i/_o          bus read-data beats (valid/ready, data)
//   bus_wack_valid_i       bus write acknowledge

module llc_mem_beat_adapter #(
  parameter int unsigned WORD_BITS      = 64,
  parameter int unsigned WORDS_PER_LINE = 2,
  parameter int unsigned LINE_ADDR_BITS = 28,
  localparam int unsigned OFF_BITS      = $clog2(WORDS_PER_LINE * WORD_BITS / 8),
  localparam int unsigned LINE          = WORDS_PER_LINE * WORD_BITS,
  localparam int unsigned BADDR         = LINE_ADDR_BITS + OFF_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_req_valid_i,
  output logic                      mem_req_ready_o,
  input  logic                      mem_req_hwrite_i,
  input  logic [LINE_ADDR_BITS-1:0] mem_req_addr_i,
  input  logic [LINE-1:0]           mem_req_line_i,
  output logic                      mem_rsp_valid_o,
  input  logic                      mem_rsp_ready_i,
  output logic [LINE-1:0]           mem_rsp_line_o,
  output logic                      bus_req_valid_o,
  input  logic                      bus_req_ready_i,
  output logic                      bus_req_write_o,
  output logic [BADDR-1:0]          bus_req_addr_o,
  output logic [WORD_BITS-1:0]      bus_req_wdata_o,
  output logic                      bus_req_last_o,
  input  logic                      bus_rd_valid_i,
  output logic                      bus_rd_ready_o,
  input  logic [WORD_BITS-1:0]      bus_rd_data_i,
  input  logic                      bus_wack_valid_i
);

  localparam int unsigned CntW     = $clog2(WORDS_PER_LINE);
  localparam int unsigned ByteBits = OFF_BITS - CntW;

  typedef enum logic [2:0] {
    StIdle,
    StRdCmd,
    StRdData,
    StRdRsp,
    StWrBeat
`ifdef LLC_MEM_WACK_EN
    , StWrAck
`endif
  } state_e;

  state_e                    state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [LINE_ADDR_BITS-1:0] addr_q, addr_d;
  logic [LINE-1:0]           wline_q, wline_d;  // latched write-back line
  logic [LINE-1:0]           rline_q, rline_d;  // read-data assembly buffer
  logic                      last_beat;
  logic [WORD_BITS-1:0]      wword;

`ifndef LLC_MEM_WACK_EN
  logic unused_wack;
  assign unused_wack = bus_wack_valid_i;
`endif

  assign last_beat      = (cnt_q == CntW'(WORDS_PER_LINE - 1));
  // In the read-command state the counter is 0, so this is the line base address.
  assign bus_req_addr_o = {addr_q, cnt_q, {ByteBits{1'b0}}};
  assign mem_rsp_line_o = rline_q;

  always_comb begin
    wword = '0;
    for (int unsigned k = 0; k < WORDS_PER_LINE; k++) begin
      if (cnt_q == CntW'(k)) wword = wline_q[k*WORD_BITS +: WORD_BITS];
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    addr_d          = addr_q;
    wline_d         = wline_q;
    rline_d         = rline_q;
    mem_req_ready_o = 1'b0;
    mem_rsp_valid_o = 1'b0;
    bus_req_valid_o = 1'b0;
    bus_req_write_o = 1'b0;
    bus_req_last_o  = 1'b0;
    bus_req_wdata_o = '0;
    bus_rd_ready_o  = 1'b0;

    unique case (state_q)
      StIdle: begin
        mem_req_ready_o = 1'b1;
        if (mem_req_valid_i) begin
          addr_d  = mem_req_addr_i;
          wline_d = mem_req_line_i;
          cnt_d   = '0;
          state_d = mem_req_hwrite_i ? StWrBeat : StRdCmd;
        end
      end
      StRdCmd: begin
        bus_req_valid_o = 1'b1;
        bus_req_last_o  = 1'b1;
        if (bus_req_ready_i) state_d = StRdData;
      end
      StRdData: begin
        bus_rd_ready_o = 1'b1;
        if (bus_rd_valid_i) begin
          for (int unsigned k = 0; k < WORDS_PER_LINE; k++) begin
            if (cnt_q == CntW'(k)) rline_d[k*WORD_BITS +: WORD_BITS] = bus_rd_data_i;
          end
          cnt_d = cnt_q + CntW'(1);  // wraps to 0 after the last beat
          if (last_beat) state_d = StRdRsp;
        end
      end
      StRdRsp: begin
        mem_rsp_valid_o = 1'b1;
        if (mem_rsp_ready_i) state_d = StIdle;
      end
      StWrBeat: begin
        bus_req_valid_o = 1'b1;
        bus_req_write_o = 1'b1;
        bus_req_wdata_o = wword;
        bus_req_last_o  = last_beat;
        if (bus_req_ready_i) begin
          cnt_d = cnt_q + CntW'(1);
`ifdef LLC_MEM_WACK_EN
          if (last_beat) state_d = StWrAck;
`else
          if (last_beat) state_d = StIdle;
`endif
        end
      end
`ifdef LLC_MEM_WACK_EN
      StWrAck: begin
        if (bus_wack_valid_i) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

endmodule

// File: tb/tb_llc_mem_beat_adapter.sv
// Testbench for llc_mem_beat_adapter (WORD_BITS=64, WORDS_PER_LINE=2, LINE_ADDR_BITS=28).
// Expected bus beats and response lines are queued when a request is driven.
// They are popped and compared when the DUT produces them. A word-level bus memory
// serves read commands, and a line-level reference memory predicts responses.
// All signals are driven and sampled on the falling clock edge.

module tb_llc_mem_beat_adapter;

  localparam int unsigned WB   = 64;
  localparam int unsigned WPL  = 2;
  localparam int unsigned LAB  = 28;
  localparam int unsigned LINE = WB * WPL;

  logic            clk;
  logic            rst;
  logic            mem_req_valid, mem_req_ready, mem_req_hwrite;
  logic [LAB-1:0]  mem_req_addr;
  logic [LINE-1:0] mem_req_line;
  logic            mem_rsp_valid, mem_rsp_ready;
  logic [LINE-1:0] mem_rsp_line;
  logic            bus_req_valid, bus_req_ready, bus_req_write, bus_req_last;
  logic [31:0]     bus_req_addr;
  logic [WB-1:0]   bus_req_wdata;
  logic            bus_rd_valid, bus_rd_ready;
  logic [WB-1:0]   bus_rd_data;
  logic            bus_wack_valid;

  llc_mem_beat_adapter #(
    .WORD_BITS     (WB),
    .WORDS_PER_LINE(WPL),
    .LINE_ADDR_BITS(LAB)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_req_valid_i (mem_req_valid),
    .mem_req_ready_o (mem_req_ready),
    .mem_req_hwrite_i(mem_req_hwrite),
    .mem_req_addr_i  (mem_req_addr),
    .mem_req_line_i  (mem_req_line),
    .mem_rsp_valid_o (mem_rsp_valid),
    .mem_rsp_ready_i (mem_rsp_ready),
    .mem_rsp_line_o  (mem_rsp_line),
    .bus_req_valid_o (bus_req_valid),
    .bus_req_ready_i (bus_req_ready),
    .bus_req_write_o (bus_req_write),
    .bus_req_addr_o  (bus_req_addr),
    .bus_req_wdata_o (bus_req_wdata),
    .bus_req_last_o  (bus_req_last),
    .bus_rd_valid_i  (bus_rd_valid),
    .bus_rd_ready_o  (bus_rd_ready),
    .bus_rd_data_i   (bus_rd_data),
    .bus_wack_valid_i(bus_wack_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [127:0] exp_bus[$];
  logic [127:0] exp_rsp[$];
  logic [63:0]  rd_q[$];
  logic [63:0]  bus_mem[logic [31:0]];
  logic [127:0] ref_mem[logic [27:0]];

  bit           stall_en    = 0;
  bit           stray_en    = 0;
  int           wack_delay  = 1;
  int           wack_cnt    = 0;
  bit           req_stalled = 0;
  bit           rsp_stalled = 0;
  logic [127:0] prev_req_beat;
  logic [127:0] prev_rsp_line;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [127:0] pack_beat(input logic w, input logic [31:0] a,
                                             input logic [63:0] d, input logic l);
    return {30'b0, w, a, d, l};
  endfunction

  function automatic logic [63:0] init_word(input logic [31:0] ba);
    return {32'hC0DE0000 ^ ba, ~ba};
  endfunction

  function automatic logic [127:0] cur_beat();
    return pack_beat(bus_req_write, bus_req_addr, bus_req_wdata, bus_req_last);
  endfunction

  // Bus side: memory model, read-data source, write acknowledge, request checker.
  initial begin : bus_side
    logic [31:0] ba;
    bus_req_ready  = 1'b0;
    bus_rd_valid   = 1'b0;
    bus_rd_data    = '0;
    bus_wack_valid = 1'b0;
    forever begin
      @(negedge clk);
      bus_wack_valid = 1'b0;
      if (wack_cnt > 0) begin
        wack_cnt--;
        if (wack_cnt == 0) bus_wack_valid = 1'b1;
      end
      if (rd_q.size() > 0) begin
        bus_rd_valid = stall_en ? 1'($urandom_range(1, 0)) : 1'b1;
        bus_rd_data  = rd_q[0];
        if (bus_rd_valid && bus_rd_ready) void'(rd_q.pop_front());
      end else if (stray_en && $urandom_range(3, 0) == 0) begin
        bus_rd_valid = 1'b1;
        bus_rd_data  = 64'hBAD0_BAD0_BAD0_BAD0;
        check_eq("stray_rd_ready", bus_rd_ready, 0);
      end else begin
        bus_rd_valid = 1'b0;
      end
      bus_req_ready = stall_en ? 1'($urandom_range(1, 0)) : 1'b1;
      if (req_stalled) begin
        check_eq("req_hold_valid", bus_req_valid, 1);
        check_eq("req_hold_beat", cur_beat(), prev_req_beat);
      end
      req_stalled = 0;
      if (bus_req_valid) begin
        if (!bus_req_ready) begin
          req_stalled   = 1;
          prev_req_beat = cur_beat();
        end else begin
          check_eq("bus_beat", cur_beat(), (exp_bus.size() > 0) ? exp_bus.pop_front() : '1);
          if (bus_req_write) begin
            bus_mem[bus_req_addr] = bus_req_wdata;
            if (bus_req_last) wack_cnt = wack_delay;
          end else begin
            for (int k = 0; k < WPL; k++) begin
              ba = {bus_req_addr[31:4], 4'b0} + 32'(k * 8);
              rd_q.push_back(bus_mem.exists(ba) ? bus_mem[ba] : init_word(ba));
            end
          end
        end
      end
    end
  end

  // LLC response side.
  initial begin : rsp_side
    mem_rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      mem_rsp_ready = stall_en ? 1'($urandom_range(1, 0)) : 1'b1;
      if (rsp_stalled) begin
        check_eq("rsp_hold_valid", mem_rsp_valid, 1);
        check_eq("rsp_hold_line", mem_rsp_line, prev_rsp_line);
      end
      rsp_stalled = 0;
      if (mem_rsp_valid) begin
        if (!mem_rsp_ready) begin
          rsp_stalled   = 1;
          prev_rsp_line = mem_rsp_line;
        end else begin
          check_eq("rsp_line", mem_rsp_line,
                   (exp_rsp.size() > 0) ? exp_rsp.pop_front() : ~mem_rsp_line);
        end
      end
    end
  end

  // Called on a falling edge; returns on the falling edge of the cycle after acceptance.
  task automatic do_req(input logic hw, input logic [27:0] a, input logic [127:0] l);
    int n;
    if (hw) begin
      for (int k = 0; k < WPL; k++) begin
        exp_bus.push_back(pack_beat(1'b1, {a, 4'b0} + 32'(k * 8), l[k*64 +: 64], k == WPL - 1));
      end
      ref_mem[a] = l;
    end else begin
      exp_bus.push_back(pack_beat(1'b0, {a, 4'b0}, 64'h0, 1'b1));
      exp_rsp.push_back(ref_mem.exists(a) ? ref_mem[a] :
                        {init_word({a, 4'h8}), init_word({a, 4'h0})});
    end
    mem_req_valid  = 1'b1;
    mem_req_hwrite = hw;
    mem_req_addr   = a;
    mem_req_line   = l;
    n = 0;
    while (!mem_req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_accept_timeout", n >= 200, 0);
    @(negedge clk);
    mem_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_bus.size() > 0 || exp_rsp.size() > 0 || rd_q.size() > 0 || !mem_req_ready)
           && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_timeout", n >= 2000, 0);
    check_eq("drain_queues", exp_bus.size() + exp_rsp.size() + rd_q.size(), 0);
  endtask

  initial begin : main
    rst            = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_hwrite = 1'b0;
    mem_req_addr   = '0;
    mem_req_line   = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_rsp_valid", mem_rsp_valid, 0);
    check_eq("rst_req_valid", bus_req_valid, 0);
    check_eq("rst_rd_ready", bus_rd_ready, 0);
    check_eq("rst_write", bus_req_write, 0);
    check_eq("rst_last", bus_req_last, 0);
    check_eq("rst_addr", bus_req_addr, 0);
    check_eq("rst_wdata", bus_req_wdata, 0);
    check_eq("rst_rsp_line", mem_rsp_line, 0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_req_ready", mem_req_ready, 1);

    // Directed line fill, zero-wait bus.
    bus_mem[32'h1230] = 64'hAAAA_AAAA_AAAA_AAAA;
    bus_mem[32'h1238] = 64'h5555_5555_5555_5555;
    ref_mem[28'h123]  = {64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA};
    do_req(1'b0, 28'h0000123, '0);
    check_eq("rd_cmd_valid", bus_req_valid, 1);
    check_eq("rd_cmd_write", bus_req_write, 0);
    check_eq("rd_cmd_addr", bus_req_addr, 32'h1230);
    check_eq("rd_cmd_last", bus_req_last, 1);
    repeat (2) @(negedge clk);
    check_eq("rd_rsp_early", mem_rsp_valid, 0);
    @(negedge clk);
    check_eq("rd_rsp_lat", mem_rsp_valid, 1);
    check_eq("rd_rsp_data", mem_rsp_line,
             {64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA});
    @(negedge clk);
    check_eq("rd_back_idle", mem_req_ready, 1);

    // Directed write-back, zero-wait bus.
    wack_delay = 5;
    do_req(1'b1, 28'h0000040, {64'h22, 64'h11});
    check_eq("wr0_valid", bus_req_valid, 1);
    check_eq("wr0_write", bus_req_write, 1);
    check_eq("wr0_addr", bus_req_addr, 32'h400);
    check_eq("wr0_wdata", bus_req_wdata, 64'h11);
    check_eq("wr0_last", bus_req_last, 0);
    check_eq("wr0_busy", mem_req_ready, 0);
    @(negedge clk);
    check_eq("wr1_addr", bus_req_addr, 32'h408);
    check_eq("wr1_wdata", bus_req_wdata, 64'h22);
    check_eq("wr1_last", bus_req_last, 1);
`ifdef LLC_MEM_WACK_EN
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("wack_wait_ready", mem_req_ready, 0);
    end
`endif
    @(negedge clk);
    check_eq("wr_done_ready", mem_req_ready, 1);
    check_eq("wr_no_rsp", mem_rsp_valid, 0);
    wait_idle();

    // Reset after the first read beat: everything in flight is discarded.
    do_req(1'b0, 28'h0000007, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_bus.delete();
    exp_rsp.delete();
    rd_q.delete();
    bus_rd_valid = 1'b0;
    req_stalled  = 0;
    rsp_stalled  = 0;
    #1;
    check_eq("midrst_rsp_valid", mem_rsp_valid, 0);
    check_eq("midrst_req_valid", bus_req_valid, 0);
    check_eq("midrst_rd_ready", bus_rd_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus_mem[32'h50] = 64'h1111_2222_3333_4444;
    bus_mem[32'h58] = 64'h5555_6666_7777_8888;
    ref_mem[28'h5]  = {64'h5555_6666_7777_8888, 64'h1111_2222_3333_4444};
    do_req(1'b0, 28'h0000005, '0);
    wait_idle();

    // Stray read-data beats while no fill is pending.
    stray_en = 1;
    repeat (10) @(negedge clk);
    do_req(1'b0, 28'h0000009, '0);
    wait_idle();

    // Random mixed traffic with 50% stalls on every handshake.
    stall_en = 1;
    for (int i = 0; i < 1000; i++) begin
      wack_delay = $urandom_range(4, 1);
      do_req(1'($urandom_range(1, 0)), 28'($urandom_range(15, 0)),
             {$urandom, $urandom, $urandom, $urandom});
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
